serial_adder: RTL and testbench

Bit-serial N-bit adder built around the team's one-bit full adder cell `full` (ports a, b, cin, sum, cout). It accepts two WIDTH-bit operands and a carry-in on a start strobe, then feeds one bit pair per clock, LSB first, into a single `full` instance, with the carry closed through a register. It sits directly upstream of the full adder cell, sequencing its inputs and collecting its sum/carry outputs, and trades WIDTH cycles of latency for one adder cell of area.

---
 rtl/serial_adder.sv | 139 +++++++++++++
 tb/tb_serial_adder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell fed LSB first, carry closed
// through carry_q; WIDTH clocks from the accepting edge to the done pulse.

module full (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout_out
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_e;

   state_e             state_q,  state_d;
   logic [WIDTH-1:0]   a_sr_q,   a_sr_d;
   logic [WIDTH-1:0]   b_sr_q,   b_sr_d;
   logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
   logic               carry_q,  carry_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic               busy_q,   busy_d;
   logic               done_q,   done_d;
   logic [WIDTH-1:0]   sum_q,    sum_d;
   logic               cout_q,   cout_d;

   logic               fa_sum;
   logic               fa_cout;
   logic [WIDTH:0]     sum_ext;

   full u_full (
      .a   (a_sr_q[0]),
      .b   (b_sr_q[0]),
      .cin (carry_q),
      .sum (fa_sum),
      .cout(fa_cout)
   );

   // New sum bit enters at the MSB; slicing the widened vector keeps WIDTH=1 legal.
   assign sum_ext = {fa_sum, sum_sr_q};

   always_comb begin
      // NOTE: every next-state signal is given its hold value first, so no path through the case can infer a latch.
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      sum_sr_d = sum_sr_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      sum_d    = sum_q;
      cout_d   = cout_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_sr_d  = a_in;
               b_sr_d  = b_in;
               carry_d = cin_in;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sum_sr_d = sum_ext[WIDTH:1];
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            carry_d  = fa_cout;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
               sum_d   = sum_ext[WIDTH:1];
               cout_d  = fa_cout;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the datapath registers are reset along with the control, because an abort must also clear the last published result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         sum_sr_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         sum_sr_q <= sum_sr_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign sum_out  = sum_q;
   assign cout_out = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 directed vectors plus a WIDTH=1
// exhaustive sweep; monitors pop expectations whenever done is seen.

module tb_serial_adder;

   typedef struct {
      logic [8:0] res;   // {cout, sum}
      int         cyc;   // cycle number at which done must be visible
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       cin8 = 1'b0;
   logic       busy8, done8, cout8;
   logic [7:0] sum8;

   logic       start1 = 1'b0;
   logic [0:0] a1 = '0, b1 = '0;
   logic       cin1 = 1'b0;
   logic       busy1, done1, cout1;
   logic [0:0] sum1;

   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   exp_t sb8[$];
   exp_t sb1[$];

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .cin_in(cin8),
      .busy(busy8), .done(done8), .sum_out(sum8), .cout_out(cout8)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1), .cin_in(cin1),
      .busy(busy1), .done(done1), .sum_out(sum1), .cout_out(cout1)
   );

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // WIDTH=8 monitor: result, latency, busy length, and hold between completions.
   initial begin
      logic [8:0] last8 = '0;
      int         run8  = 0;
      exp_t       e;
      forever begin
         @(negedge clk);
         if (rst) begin
            last8 = '0;
            run8  = 0;
         end else begin
            if (busy8) run8++;
            if (done8) begin
               if (sb8.size() == 0) begin
                  check("w8_spurious_done", {31'd0, done8}, 32'd0);
               end else begin
                  e = sb8.pop_front();
                  check("w8_result",  {23'd0, cout8, sum8}, {23'd0, e.res});
                  check("w8_latency", cyc, e.cyc);
                  check("w8_busy_cycles", run8, 8);
               end
               last8 = {cout8, sum8};
               run8  = 0;
            end else begin
               check("w8_hold", {23'd0, cout8, sum8}, {23'd0, last8});
            end
         end
      end
   end

   // WIDTH=1 monitor.
   initial begin
      int   run1 = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            run1 = 0;
         end else begin
            if (busy1) run1++;
            if (done1) begin
               if (sb1.size() == 0) begin
                  check("w1_spurious_done", {31'd0, done1}, 32'd0);
               end else begin
                  e = sb1.pop_front();
                  check("w1_result",  {30'd0, cout1, sum1}, {23'd0, e.res});
                  check("w1_latency", cyc, e.cyc);
                  check("w1_busy_cycles", run1, 1);
               end
               run1 = 0;
            end
         end
      end
   end

   // Issue one WIDTH=8 addition with a hand-computed expected result.
   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [7:0] exp_sum, input logic exp_cout);
      int guard = 0;
      @(negedge clk);
      while (busy8 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("w8_issue_timeout", guard, 0 + (guard < 100 ? guard : 0));
      a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
      sb8.push_back('{res: {exp_cout, exp_sum}, cyc: cyc + 1 + 8});
      @(negedge clk);
      start8 = 1'b0;
      a8 = ~a; b8 = ~b; cin8 = ~c;   // post-acceptance changes must not matter
   endtask

   task automatic drain(input string name);
      int guard = 0;
      while ((sb8.size() != 0 || sb1.size() != 0) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check(name, sb8.size() + sb1.size(), 0);
      @(negedge clk);
   endtask

   logic [7:0] bb_a [4] = '{8'h12, 8'hF0, 8'h99, 8'h01};
   logic [7:0] bb_b [4] = '{8'h34, 8'h0F, 8'h66, 8'h02};
   logic       bb_c [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
   logic [8:0] bb_r [4] = '{9'h046, 9'h100, 9'h0FF, 9'h004};

   initial begin
      int n;
      int guard;
      logic [1:0] ref1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy",  {31'd0, busy8}, 32'd0);
      check("rst_done",  {31'd0, done8}, 32'd0);
      check("rst_sum",   {24'd0, sum8},  32'd0);
      check("rst_cout",  {31'd0, cout8}, 32'd0);
      #2 rst = 1'b0;

      // Directed vectors
      issue8(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
      check("busy_after_accept", {31'd0, busy8}, 32'd1);
      issue8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      issue8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
      issue8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
      issue8(8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
      issue8(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1);
      drain("drain_directed");

      // Start while busy is ignored
      issue8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
      repeat (2) @(negedge clk);
      a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      drain("drain_busy_ignore");
      repeat (12) @(negedge clk);   // a dropped request would show up as a spurious done
      check("busy_ignore_sum", {24'd0, sum8}, 32'h30);

      // Reset mid-operation
      issue8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_busy", {31'd0, busy8}, 32'd0);
      check("abort_done", {31'd0, done8}, 32'd0);
      check("abort_sum",  {24'd0, sum8},  32'd0);
      check("abort_cout", {31'd0, cout8}, 32'd0);
      sb8.delete();
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (12) @(negedge clk);
      check("abort_no_done_sum", {24'd0, sum8}, 32'd0);
      issue8(8'h02, 8'h03, 1'b0, 8'h05, 1'b0);
      drain("drain_after_abort");

      // start held high: back-to-back accepts every 9 clocks
      n = 0;
      guard = 0;
      while (n < 4 && guard < 100) begin
         @(negedge clk);
         guard++;
         if (!busy8) begin
            a8 = bb_a[n]; b8 = bb_b[n]; cin8 = bb_c[n]; start8 = 1'b1;
            sb8.push_back('{res: bb_r[n], cyc: cyc + 1 + 8});
            n++;
         end
      end
      check("b2b_accepts", n, 4);
      @(negedge clk);
      start8 = 1'b0;
      drain("drain_b2b");

      // WIDTH=1 exhaustive sweep
      for (int i = 0; i < 8; i++) begin
         guard = 0;
         while (busy1 && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i);
         ref1 = 2'(a1) + 2'(b1) + 2'(cin1);
         start1 = 1'b1;
         sb1.push_back('{res: {7'd0, ref1}, cyc: cyc + 1 + 1});
         @(negedge clk);
         start1 = 1'b0;
         a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
      end
      drain("drain_w1");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
      $fatal(1);
   end

endmodule
